// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a 16x oversampling baud divider.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data.
module uart_tx #(
    parameter int unsigned CLOCK     = 50_000_000,
    parameter int unsigned BAUD_RATE = 19200,
    parameter int unsigned N_BITS    = 8,
    parameter int unsigned SB_TICKS  = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_tx_start,
    input  logic [N_BITS-1:0] i_tx_data,
    output logic              o_tx,
    output logic              o_tx_done_tick,
    output logic              o_busy
);

    localparam int unsigned DIV  = (CLOCK + BAUD_RATE * 8) / (BAUD_RATE * 16);
    localparam int unsigned DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SMAX = (SB_TICKS > 16) ? SB_TICKS : 16;
    localparam int unsigned SW   = $clog2(SMAX);
    localparam int unsigned NW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state;
    logic [DW-1:0]     div_cnt;
    logic [SW-1:0]     s_cnt;
    logic [NW-1:0]     n_cnt;
    logic [N_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
    logic              par;
`endif

    logic tick;
    logic last_stop;
    logic accept;

    // Oversample tick, final stop cycle and frame acceptance.
    always_comb begin
        tick      = (div_cnt == DW'(DIV - 1));
        last_stop = (state == STOP) && tick && (s_cnt == SW'(SB_TICKS - 1));
        accept    = i_tx_start && ((state == IDLE) || last_stop);
    end

    // The done tick is decoded from registered state only.
    assign o_tx_done_tick = last_stop;

    // Frame sequencer, baud divider and serial output register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            s_cnt   <= '0;
            n_cnt   <= '0;
            shreg   <= '0;
            o_tx    <= 1'b1;
            o_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (state == IDLE || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (accept) begin
                state  <= START;
                shreg  <= i_tx_data;
                s_cnt  <= '0;
                n_cnt  <= '0;
                o_tx   <= 1'b0;
                o_busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
                par    <= ^i_tx_data;
`endif
            end else begin
                unique case (state)
                    IDLE: begin
                        o_tx   <= 1'b1;
                        o_busy <= 1'b0;
                    end
                    START: begin
                        if (tick) begin
                            if (s_cnt == SW'(15)) begin
                                s_cnt <= '0;
                                state <= DATA;
                                o_tx  <= shreg[0];
                            end else begin
                                s_cnt <= s_cnt + SW'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (s_cnt == SW'(15)) begin
                                s_cnt <= '0;
                                if (n_cnt == NW'(N_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                                    state <= PARITY;
                                    o_tx  <= par;
`else
                                    state <= STOP;
                                    o_tx  <= 1'b1;
`endif
                                end else begin
                                    n_cnt <= n_cnt + NW'(1);
                                    shreg <= shreg >> 1;
                                    o_tx  <= shreg[1];
                                end
                            end else begin
                                s_cnt <= s_cnt + SW'(1);
                            end
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (tick) begin
                            if (s_cnt == SW'(15)) begin
                                s_cnt <= '0;
                                state <= STOP;
                                o_tx  <= 1'b1;
                            end else begin
                                s_cnt <= s_cnt + SW'(1);
                            end
                        end
                    end
`endif
                    STOP: begin
                        if (tick) begin
                            if (s_cnt == SW'(SB_TICKS - 1)) begin
                                s_cnt  <= '0;
                                state  <= IDLE;
                                o_tx   <= 1'b1;
                                o_busy <= 1'b0;
                            end else begin
                                s_cnt <= s_cnt + SW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, handshake and reset.
// Fast instance uses DIV=1 (BIT=16); second instance uses default rates.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int BIT_T = 16;
    localparam int D_T   = (9 + PB) * BIT_T + 16;
    localparam int BIT_D = 2608;
    localparam int D_D   = (9 + PB) * BIT_D + 16 * 163;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       tx, done, busy;
    logic       d_start;
    logic [7:0] d_data;
    logic       d_tx, d_done, d_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLOCK(1_600_000), .BAUD_RATE(100_000), .N_BITS(8), .SB_TICKS(16)
    ) u_fast (
        .i_clock(clk), .i_reset(rst), .i_tx_start(start), .i_tx_data(data),
        .o_tx(tx), .o_tx_done_tick(done), .o_busy(busy)
    );

    uart_tx u_def (
        .i_clock(clk), .i_reset(rst), .i_tx_start(d_start), .i_tx_data(d_data),
        .o_tx(d_tx), .o_tx_done_tick(d_done), .o_busy(d_busy)
    );

    // Expected line level k cycles after the accept cycle.
    function automatic logic exp_line(input logic [7:0] d, input int k, input int bl);
        int idx;
        if (k < 1) return 1'b1;
        idx = (k - 1) / bl;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (PB == 1 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", tx); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        if (d_tx !== 1'b1) begin n_bad++; $display("FAIL reset_dtx got %b want 1", d_tx); end
        if (d_busy !== 1'b0) begin n_bad++; $display("FAIL reset_dbusy got %b want 0", d_busy); end
        if (d_done !== 1'b0) begin n_bad++; $display("FAIL reset_ddone got %b want 0", d_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] d);
        logic et;
        start = 1'b1;
        data  = d;
        for (int k = 1; k <= D_T + 3; k++) begin
            @(negedge clk);
            et = exp_line(d, k, BIT_T);
            n_cmp += 3;
            if (tx !== et) begin n_bad++; $display("FAIL frame_%h_tx k=%0d got %b want %b", d, k, tx, et); end
            if (busy !== (k <= D_T)) begin n_bad++; $display("FAIL frame_%h_busy k=%0d got %b", d, k, busy); end
            if (done !== (k == D_T)) begin n_bad++; $display("FAIL frame_%h_done k=%0d got %b", d, k, done); end
            if (k == 1) begin
                start = 1'b0;
                data  = ~d;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2;
        logic et;
        d1 = 8'hA3;
        d2 = 8'h0F;
        start = 1'b1;
        data  = d1;
        for (int k = 1; k <= 2 * D_T + 2; k++) begin
            @(negedge clk);
            et = (k <= D_T) ? exp_line(d1, k, BIT_T) : exp_line(d2, k - D_T, BIT_T);
            n_cmp += 3;
            if (tx !== et) begin n_bad++; $display("FAIL b2b_tx k=%0d got %b want %b", k, tx, et); end
            if (busy !== (k <= 2 * D_T)) begin n_bad++; $display("FAIL b2b_busy k=%0d got %b", k, busy); end
            if (done !== (k == D_T || k == 2 * D_T)) begin n_bad++; $display("FAIL b2b_done k=%0d got %b", k, done); end
            if (k == 1) start = 1'b0;
            if (k == D_T) begin
                start = 1'b1;
                data  = d2;
            end
            if (k == D_T + 1) start = 1'b0;
        end
    endtask

    task automatic test_ignore_busy();
        logic et;
        int ndone;
        ndone = 0;
        start = 1'b1;
        data  = 8'h00;
        for (int k = 1; k <= D_T + 20; k++) begin
            @(negedge clk);
            et = exp_line(8'h00, k, BIT_T);
            if (done === 1'b1) ndone++;
            n_cmp += 3;
            if (tx !== et) begin n_bad++; $display("FAIL ignore_tx k=%0d got %b want %b", k, tx, et); end
            if (busy !== (k <= D_T)) begin n_bad++; $display("FAIL ignore_busy k=%0d got %b", k, busy); end
            if (done !== (k == D_T)) begin n_bad++; $display("FAIL ignore_done k=%0d got %b", k, done); end
            if (k == 1) start = 1'b0;
            if (k == 50) begin
                start = 1'b1;
                data  = 8'hFF;
            end
            if (k == 51) start = 1'b0;
        end
        n_cmp++;
        if (ndone !== 1) begin n_bad++; $display("FAIL ignore_ndone got %0d want 1", ndone); end
    endtask

    task automatic test_reset_mid();
        logic et, eb, ed;
        start = 1'b1;
        data  = 8'h5A;
        for (int k = 1; k <= 80 + D_T + 2; k++) begin
            @(negedge clk);
            if (k <= 70) begin
                et = exp_line(8'h5A, k, BIT_T);
                eb = 1'b1;
                ed = 1'b0;
            end else if (k <= 80) begin
                et = 1'b1;
                eb = 1'b0;
                ed = 1'b0;
            end else begin
                et = exp_line(8'h3C, k - 80, BIT_T);
                eb = (k - 80 <= D_T);
                ed = (k - 80 == D_T);
            end
            n_cmp += 3;
            if (tx !== et) begin n_bad++; $display("FAIL rstmid_tx k=%0d got %b want %b", k, tx, et); end
            if (busy !== eb) begin n_bad++; $display("FAIL rstmid_busy k=%0d got %b want %b", k, busy, eb); end
            if (done !== ed) begin n_bad++; $display("FAIL rstmid_done k=%0d got %b want %b", k, done, ed); end
            if (k == 1) start = 1'b0;
            if (k == 70) rst = 1'b1;
            if (k == 71) rst = 1'b0;
            if (k == 80) begin
                start = 1'b1;
                data  = 8'h3C;
            end
            if (k == 81) start = 1'b0;
        end
    endtask

    task automatic test_defaults();
        logic et;
        d_start = 1'b1;
        d_data  = 8'h41;
        for (int k = 1; k <= D_D + 2; k++) begin
            @(negedge clk);
            et = exp_line(8'h41, k, BIT_D);
            n_cmp += 3;
            if (d_tx !== et) begin n_bad++; $display("FAIL def_tx k=%0d got %b want %b", k, d_tx, et); end
            if (d_busy !== (k <= D_D)) begin n_bad++; $display("FAIL def_busy k=%0d got %b", k, d_busy); end
            if (d_done !== (k == D_D)) begin n_bad++; $display("FAIL def_done k=%0d got %b", k, d_done); end
            if (k == 1) d_start = 1'b0;
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data    = 8'h00;
        d_start = 1'b0;
        d_data  = 8'h00;
        test_reset();
        test_frame(8'h55);
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_frame(8'h07);
        test_frame(8'h03);
        test_defaults();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
